// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci-detector sweep checker.
// Contents: sweep FSM state enum, 4-bit golden hit mask, code-count helper.
package fib_pkg;

  localparam int unsigned FIB_W = 4;

  // Codes 0,1,2,3,5,8,13 are Fibonacci numbers below 16.
  localparam logic [15:0] FIB_MASK_4 = 16'h212F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } sweep_state_e;

  // Number of codes swept for a detector of the given input width.
  function automatic int unsigned num_codes(input int unsigned w);
    return 32'(1) << w;
  endfunction

endpackage

// File: rtl/fib_settle_timer.sv
// Loadable down-counter that times the settle window for each code.
// Ports: clk, rst_n (async active-low), load/load_val (preset count),
//        tick (decrement while nonzero), expire_c (count is zero, combinational).
module fib_settle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire_c
);

  logic [W-1:0] count;

  // Load has priority; count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire_c = (count == '0);

endmodule

// File: rtl/fib_sweep_ctrl.sv
// Self-test sequencer: sweeps every detector input code, samples the detector
// result after a settle window, builds a hit mask / hit count and compares the
// mask against a golden constant.
// Ports: clk, rst_n (async active-low), start, abort (host control);
//        dut_in (code to detector), dut_out (detector result);
//        busy, done (one-cycle pulse), pass, hit_mask, hit_count (results).
module fib_sweep_ctrl
  import fib_pkg::*;
#(
  parameter int unsigned                      WIDTH         = FIB_W,
  parameter int unsigned                      SETTLE        = 2,
  parameter logic [num_codes(WIDTH)-1:0]      EXPECTED_MASK = FIB_MASK_4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic [WIDTH-1:0]              dut_in,
  input  logic                          dut_out,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [num_codes(WIDTH)-1:0]   hit_mask,
  output logic [WIDTH:0]                hit_count
);

  localparam int unsigned      N           = num_codes(WIDTH);
  localparam int unsigned      CW          = WIDTH + 1;
  localparam int unsigned      TW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned      SETTLE_LOAD = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [WIDTH-1:0] LAST_CODE   = WIDTH'(N - 1);
  // With no settle cycles each code goes straight to its sample cycle.
  localparam sweep_state_e     CODE_ENTRY  = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  sweep_state_e     state, state_d;
  logic [WIDTH-1:0] dut_in_d;
  logic [N-1:0]     mask_d;
  logic [CW-1:0]    count_d;
  logic             pass_d, busy_d, done_d;
  logic             timer_load, timer_tick, timer_expire;

  fib_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (TW'(SETTLE_LOAD)),
    .tick     (timer_tick),
    .expire_c (timer_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dut_in    <= '0;
      hit_mask  <= '0;
      hit_count <= '0;
      pass      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      dut_in    <= dut_in_d;
      hit_mask  <= mask_d;
      hit_count <= count_d;
      pass      <= pass_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state;
    dut_in_d   = dut_in;
    mask_d     = hit_mask;
    count_d    = hit_count;
    pass_d     = pass;
    timer_load = 1'b0;
    timer_tick = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = CODE_ENTRY;
          dut_in_d   = '0;
          mask_d     = '0;
          count_d    = '0;
          pass_d     = 1'b0;
          timer_load = 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer_expire) state_d = S_SAMPLE;
        else              timer_tick = 1'b1;
      end
      S_SAMPLE: begin
        mask_d[dut_in] = dut_out;
        count_d        = hit_count + CW'(dut_out);
        if (dut_in == LAST_CODE) begin
          state_d = S_DONE;
          // Judge using the mask including this final sample.
          pass_d  = (mask_d == EXPECTED_MASK);
        end else begin
          dut_in_d   = dut_in + WIDTH'(1);
          state_d    = CODE_ENTRY;
          timer_load = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything and discards partial results.
    if (abort) begin
      state_d    = S_IDLE;
      dut_in_d   = '0;
      mask_d     = '0;
      count_d    = '0;
      pass_d     = 1'b0;
      timer_load = 1'b0;
      timer_tick = 1'b0;
    end

    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
module tb_fib_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with SETTLE=2 (suffix 2) and SETTLE=0 (suffix 0).
  logic        start2, abort2, dut_out2, busy2, done2, pass2;
  logic [3:0]  dut_in2;
  logic [15:0] hit_mask2;
  logic [4:0]  hit_count2;
  logic        start0, abort0, dut_out0, busy0, done0, pass0;
  logic [3:0]  dut_in0;
  logic [15:0] hit_mask0;
  logic [4:0]  hit_count0;

  // Behavioural detector: response table indexed by code.
  logic [15:0] det_tab;
  assign dut_out2 = det_tab[dut_in2];
  assign dut_out0 = det_tab[dut_in0];

  fib_sweep_ctrl #(.WIDTH(4), .SETTLE(2), .EXPECTED_MASK(16'h212F)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
    .pass(pass2), .hit_mask(hit_mask2), .hit_count(hit_count2));

  fib_sweep_ctrl #(.WIDTH(4), .SETTLE(0), .EXPECTED_MASK(16'h212F)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .pass(pass0), .hit_mask(hit_mask0), .hit_count(hit_count0));

  logic        use0;
  logic        c_busy, c_done, c_pass;
  logic [3:0]  c_dut_in;
  logic [15:0] c_mask;
  logic [4:0]  c_count;
  assign c_busy   = use0 ? busy0      : busy2;
  assign c_done   = use0 ? done0      : done2;
  assign c_pass   = use0 ? pass0      : pass2;
  assign c_dut_in = use0 ? dut_in0    : dut_in2;
  assign c_mask   = use0 ? hit_mask0  : hit_mask2;
  assign c_count  = use0 ? hit_count0 : hit_count2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (use0) start0 = v; else start2 = v;
  endtask

  // Fibonacci membership computed directly from the recurrence.
  function automatic logic [15:0] fib_mask();
    logic [15:0] m = '0;
    int a = 0, b = 1, t;
    while (a < 16) begin
      m[a] = 1'b1;
      t = a + b; a = b; b = t;
    end
    return m;
  endfunction

  // One full sweep; expected busy length is N*(SETTLE+1).
  task automatic run_sweep(input logic [15:0] det, input logic [15:0] emask,
                           input int ecnt, input logic epass, input int restart_at,
                           input string nm);
    int n = 0;
    int ebusy = use0 ? 16 : 48;
    det_tab = det;
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    while (c_busy === 1'b1 && n < 400) begin
      n++;
      set_start(n == restart_at);
      @(negedge clk);
    end
    set_start(1'b0);
    chk({nm, "_busy_len"}, 32'(n), 32'(ebusy));
    chk({nm, "_done"}, 32'(c_done), 32'd1);
    chk({nm, "_mask"}, 32'(c_mask), 32'(emask));
    chk({nm, "_count"}, 32'(c_count), 32'(ecnt));
    chk({nm, "_pass"}, 32'(c_pass), 32'(epass));
    chk({nm, "_last_code"}, 32'(c_dut_in), 32'd15);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(c_done), 32'd0);
    chk({nm, "_pass_hold"}, 32'(c_pass), 32'(epass));
  endtask

  // Counts done pulses over a window; none are expected.
  task automatic no_done(input string nm, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (c_done === 1'b1) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [15:0] det;
    logic [15:0] emask;
    int          ecnt;
    logic        epass;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] gold;

  initial begin
    int n;
    rst_n = 1'b0; start2 = 0; abort2 = 0; start0 = 0; abort0 = 0;
    use0 = 1'b0;
    gold = fib_mask();
    det_tab = gold;

    vecs[0] = '{gold,           16'h212F, 7,  1'b1};
    vecs[1] = '{16'h0000,       16'h0000, 0,  1'b0};
    vecs[2] = '{gold | 16'h0010, 16'h213F, 8, 1'b0};
    vecs[3] = '{16'hFFFF,       16'hFFFF, 16, 1'b0};

    repeat (3) @(negedge clk);
    chk("gold_const", 32'(gold), 32'h212F);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_outs2", {pass2, hit_count2, hit_mask2, dut_in2}, 32'd0);
    chk("rst_outs0", {busy0, done0, pass0, hit_count0, hit_mask0, dut_in0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven sweeps on both settle configurations.
    for (int s = 0; s < 2; s++) begin
      use0 = (s == 1);
      for (int i = 0; i < 4; i++)
        run_sweep(vecs[i].det, vecs[i].emask, vecs[i].ecnt, vecs[i].epass, -1,
                  $sformatf("s%0d_vec%0d", s, i));
    end

    // start re-asserted mid-sweep is ignored.
    use0 = 1'b0;
    run_sweep(gold, 16'h212F, 7, 1'b1, 10, "restart_ignored");

    // start+abort together in IDLE: stays idle.
    @(negedge clk); start2 = 1'b1; abort2 = 1'b1;
    @(negedge clk); start2 = 1'b0; abort2 = 1'b0;
    chk("start_abort_idle_busy", 32'(busy2), 32'd0);
    no_done("start_abort_no_done", 60);
    chk("start_abort_still_idle", 32'(busy2), 32'd0);

    // Abort while code 5 is being driven.
    det_tab = gold;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n = 0;
    while (dut_in2 !== 4'd5 && n < 200) begin n++; @(negedge clk); end
    chk("abort_reach_code5", 32'(dut_in2), 32'd5);
    abort2 = 1'b1;
    @(negedge clk); abort2 = 1'b0;
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_dut_in", 32'(dut_in2), 32'd0);
    chk("abort_mask", 32'(hit_mask2), 32'd0);
    chk("abort_count", 32'(hit_count2), 32'd0);
    no_done("abort_no_done", 60);
    run_sweep(gold, 16'h212F, 7, 1'b1, -1, "after_abort");

    // Asynchronous reset mid-sweep.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", 32'(busy2), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy2), 32'd0);
    chk("async_rst_outs", {done2, pass2, hit_count2, hit_mask2, dut_in2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    no_done("post_reset_no_done", 60);

    // Random detector responses against the reference expectation.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (i == 0) d = gold;
      use0 = i[0];
      run_sweep(d, d, $countones(d), (d == gold), -1, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
